// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types (register index, primary opcode).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_ADDIU = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_LL    = 6'h30
  } opcode_t;

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_scoreboard_pkg.sv
//------------------------------------------------------------------------------
// Module      : fwd_scoreboard_pkg
// Description : Scoreboard entry, stall FSM state and select encodings.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fwd_scoreboard_pkg;

  import cpu_types_pkg::*;

  typedef struct packed {
    logic     valid;
    logic     wen;
    regbits_t wsel;
    logic     is_load;
  } sb_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_t;

  localparam int FWD_RF = 0;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 3;

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_scoreboard_if.sv
//------------------------------------------------------------------------------
// Module      : fwd_hazard_scoreboard_if
// Description : Signal bundle between the ID/EX control and the scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fwd_hazard_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2
) (
  input logic CLK
);

  logic                       nRST;
  logic                       issue_valid;
  logic                       issue_wen;
  logic [4:0]                 issue_wsel;
  logic                       issue_is_load;
  logic [NUM_SRC*5-1:0]       id_src;
  logic [NUM_SRC-1:0]         id_src_used;
  logic                       stall_in;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       hazard_stall;
  logic                       ex_entry_valid;

  modport sb (
    input  CLK, nRST, issue_valid, issue_wen, issue_wsel, issue_is_load,
    input  id_src, id_src_used, stall_in, flush,
    output fwd_sel, hazard_stall, ex_entry_valid
  );

  modport tb (
    input  CLK, fwd_sel, hazard_stall, ex_entry_valid,
    output nRST, issue_valid, issue_wen, issue_wsel, issue_is_load,
    output id_src, id_src_used, stall_in, flush
  );

endinterface

`default_nettype wire

// File: rtl/fwd_hazard_scoreboard_prio_match.sv
//------------------------------------------------------------------------------
// Module      : fwd_prio_match
// Description : One EX operand against the post-EX producers; youngest wins.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_prio_match
  import cpu_types_pkg::*;
  import fwd_scoreboard_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  sb_entry_t [FWD_DEPTH:1] producers,
  input  regbits_t                src,
  input  logic                    used,
  output logic [SEL_W-1:0]        sel
);

  logic w_unused_load;

  // Oldest-to-youngest scan so the nearest producer overrides.
  always_comb begin
    sel           = SEL_W'(FWD_RF);
    w_unused_load = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      w_unused_load = w_unused_load ^ producers[k].is_load;
      if (producers[k].valid && producers[k].wen &&
          (producers[k].wsel == src) && (src != '0) && used) begin
        sel = SEL_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : fwd_hazard_scoreboard
// Description : In-flight writer scoreboard driving EX forwarding and load-use stall.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_scoreboard
  import cpu_types_pkg::*;
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int FWD_DEPTH      = 2,
  parameter int LOAD_USE_STALL = 1,
  parameter int SEL_W          = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [4:0]               issue_wsel,
  input  logic                     issue_is_load,
  input  logic [NUM_SRC*5-1:0]     id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     stall_in,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     hazard_stall,
  output logic                     ex_entry_valid
);

  sb_entry_t [FWD_DEPTH:0]      r_entry;
  logic [NUM_SRC*REG_W-1:0]     r_ex_src;
  logic [NUM_SRC-1:0]           r_ex_used;
  stall_state_t                 r_state;
  stall_state_t                 w_state_nxt;
  logic [CNT_W-1:0]             r_cnt;
  logic [CNT_W-1:0]             w_cnt_nxt;
  logic                         w_adv;
  logic                         w_hit;
  logic                         w_accept;

  assign w_adv          = !stall_in;
  assign w_accept       = issue_valid && !hazard_stall && !flush;
  assign ex_entry_valid = r_entry[0].valid;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && issue_valid && (id_src[i*REG_W +: REG_W] != '0) &&
          r_entry[0].valid && r_entry[0].is_load && r_entry[0].wen &&
          (r_entry[0].wsel == id_src[i*REG_W +: REG_W])) begin
        w_hit = 1'b1;
      end
    end
  end

  // Flush overrides any stall in progress; nothing moves while stall_in is high.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    hazard_stall = (r_state == STALL) || w_hit;
    if (w_adv) begin
      if (flush) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_hit && (LOAD_USE_STALL > 1)) begin
              w_state_nxt = STALL;
              w_cnt_nxt   = CNT_W'(LOAD_USE_STALL - 1);
            end
          end
          STALL: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nxt = IDLE;
            end
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_entry   <= '0;
      r_ex_src  <= '0;
      r_ex_used <= '0;
    end else if (w_adv) begin
      r_entry[FWD_DEPTH:1] <= r_entry[FWD_DEPTH-1:0];
      if (w_accept) begin
        r_entry[0] <= '{valid: 1'b1, wen: issue_wen, wsel: issue_wsel, is_load: issue_is_load};
        r_ex_src   <= id_src;
        r_ex_used  <= id_src_used;
      end else begin
        r_entry[0] <= '0;
        r_ex_used  <= '0;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_prio_match #(
        .FWD_DEPTH (FWD_DEPTH),
        .SEL_W     (SEL_W)
      ) u_match (
        .producers (r_entry[FWD_DEPTH:1]),
        .src       (r_ex_src[i*REG_W +: REG_W]),
        .used      (r_ex_used[i]),
        .sel       (fwd_sel[i*SEL_W +: SEL_W])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : tb_fwd_hazard_scoreboard
// Description : Directed bench; two instances (stall length 1 and 3) share stimulus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fwd_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.NUM_SRC(2), .SEL_W(2)) bus (.CLK(clk));

  logic [3:0] fwd_sel3;
  logic       hs3;
  logic       eev3;

  int n_cmp = 0;
  int n_err = 0;

  fwd_hazard_scoreboard #(
    .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_USE_STALL(1)
  ) dut_lus1 (
    .CLK            (bus.CLK),
    .nRST           (bus.nRST),
    .issue_valid    (bus.issue_valid),
    .issue_wen      (bus.issue_wen),
    .issue_wsel     (bus.issue_wsel),
    .issue_is_load  (bus.issue_is_load),
    .id_src         (bus.id_src),
    .id_src_used    (bus.id_src_used),
    .stall_in       (bus.stall_in),
    .flush          (bus.flush),
    .fwd_sel        (bus.fwd_sel),
    .hazard_stall   (bus.hazard_stall),
    .ex_entry_valid (bus.ex_entry_valid)
  );

  fwd_hazard_scoreboard #(
    .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_USE_STALL(3)
  ) dut_lus3 (
    .CLK            (clk),
    .nRST           (bus.nRST),
    .issue_valid    (bus.issue_valid),
    .issue_wen      (bus.issue_wen),
    .issue_wsel     (bus.issue_wsel),
    .issue_is_load  (bus.issue_is_load),
    .id_src         (bus.id_src),
    .id_src_used    (bus.id_src_used),
    .stall_in       (bus.stall_in),
    .flush          (bus.flush),
    .fwd_sel        (fwd_sel3),
    .hazard_stall   (hs3),
    .ex_entry_valid (eev3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic w, input int wsel, input logic ld,
                       input int s0, input int s1, input logic [1:0] used);
    bus.issue_valid   = v;
    bus.issue_wen     = w;
    bus.issue_wsel    = 5'(wsel);
    bus.issue_is_load = ld;
    bus.id_src        = {5'(s1), 5'(s0)};
    bus.id_src_used   = used;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.nRST     = 1'b0;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 2'b00);
    step();
    step();
    chk("rst_fwd1", 8'(bus.fwd_sel), 8'h0);
    chk("rst_hs1",  8'(bus.hazard_stall), 8'h0);
    chk("rst_eev1", 8'(bus.ex_entry_valid), 8'h0);
    chk("rst_eev3", 8'(eev3), 8'h0);
    bus.nRST = 1'b1;

    // ADD $3 ; SUB $5,$3,$3 back to back
    drive(1'b1, 1'b1, 3, 1'b0, 1, 2, 2'b11);
    chk("alu_hs", 8'(bus.hazard_stall), 8'h0);
    step();
    drive(1'b1, 1'b1, 5, 1'b0, 3, 3, 2'b11);
    chk("add_in_ex", 8'(bus.ex_entry_valid), 8'h1);
    chk("add_no_fwd", 8'(bus.fwd_sel), 8'h0);
    step();
    drive(1'b1, 1'b1, 8, 1'b0, 0, 0, 2'b00);
    chk("b2b_fwd_mem", 8'(bus.fwd_sel), 8'h5);
    step();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 2'b00);
    chk("unused_no_fwd", 8'(bus.fwd_sel), 8'h0);
    step();
    drive(1'b1, 1'b1, 9, 1'b0, 8, 8, 2'b11);
    chk("nop_bubble", 8'(bus.ex_entry_valid), 8'h0);
    step();

    // OR $9,$8,$8 after NOP reads ADD $8 from WB
    drive(1'b1, 1'b1, 4, 1'b0, 0, 0, 2'b00);
    chk("nop_fwd_wb", 8'(bus.fwd_sel), 8'hA);
    chk("nop_fwd_wb3", 8'(fwd_sel3), 8'hA);
    step();
    drive(1'b1, 1'b1, 4, 1'b0, 0, 0, 2'b00);
    step();
    drive(1'b1, 1'b1, 10, 1'b0, 4, 9, 2'b11);
    step();
    drive(1'b1, 1'b1, 0, 1'b1, 0, 0, 2'b00);
    chk("prio_youngest", 8'(bus.fwd_sel), 8'h1);
    step();

    // LW $0 then a reader of $0
    drive(1'b1, 1'b1, 11, 1'b0, 0, 0, 2'b11);
    chk("r0_no_hazard", 8'(bus.hazard_stall), 8'h0);
    chk("r0_no_hazard3", 8'(hs3), 8'h0);
    step();
    drive(1'b1, 1'b1, 2, 1'b1, 1, 0, 2'b01);
    chk("r0_no_fwd", 8'(bus.fwd_sel), 8'h0);
    step();

    // Load-use, single-cycle stall
    drive(1'b1, 1'b1, 6, 1'b0, 2, 7, 2'b11);
    chk("lu1_stall_on", 8'(bus.hazard_stall), 8'h1);
    step();
    chk("lu1_stall_off", 8'(bus.hazard_stall), 8'h0);
    chk("lu1_bubble", 8'(bus.ex_entry_valid), 8'h0);
    step();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 2'b00);
    chk("lu1_fwd_wb", 8'(bus.fwd_sel), 8'h2);
    chk("lu1_consumer_ex", 8'(bus.ex_entry_valid), 8'h1);

    bus.nRST = 1'b0;
    #1;
    chk("rst2_fwd1", 8'(bus.fwd_sel), 8'h0);
    chk("rst2_eev1", 8'(bus.ex_entry_valid), 8'h0);
    step();
    bus.nRST = 1'b1;

    // Load-use, three-cycle stall with a two-cycle freeze in the middle
    drive(1'b1, 1'b1, 2, 1'b1, 0, 0, 2'b00);
    step();
    drive(1'b1, 1'b1, 6, 1'b0, 2, 0, 2'b01);
    chk("lu3_stall_1", 8'(hs3), 8'h1);
    chk("lu1_stall_1", 8'(bus.hazard_stall), 8'h1);
    step();
    chk("lu3_stall_2", 8'(hs3), 8'h1);
    chk("lu1_done", 8'(bus.hazard_stall), 8'h0);
    step();
    bus.stall_in = 1'b1;
    #1;
    chk("frz_hs3_a", 8'(hs3), 8'h1);
    chk("frz_fwd1_a", 8'(bus.fwd_sel), 8'h2);
    step();
    chk("frz_hs3_b", 8'(hs3), 8'h1);
    chk("frz_fwd1_b", 8'(bus.fwd_sel), 8'h2);
    step();
    bus.stall_in = 1'b0;
    #1;
    chk("lu3_cnt_held", 8'(hs3), 8'h1);
    step();
    chk("lu3_release", 8'(hs3), 8'h0);
    step();

    // Flush during the second stall cycle
    drive(1'b1, 1'b1, 3, 1'b1, 0, 0, 2'b00);
    chk("lu3_consumer_ex", 8'(eev3), 8'h1);
    step();
    drive(1'b1, 1'b1, 7, 1'b0, 3, 0, 2'b01);
    chk("fl_stall_1", 8'(hs3), 8'h1);
    step();
    bus.flush = 1'b1;
    #1;
    chk("fl_stall_2", 8'(hs3), 8'h1);
    step();
    bus.flush = 1'b0;
    drive(1'b1, 1'b1, 3, 1'b1, 0, 0, 2'b00);
    chk("fl_hs_clear", 8'(hs3), 8'h0);
    chk("fl_bubble", 8'(eev3), 8'h0);
    step();

    // Reset asserted mid-stall
    drive(1'b1, 1'b1, 7, 1'b0, 3, 3, 2'b11);
    chk("rs_stall_1", 8'(hs3), 8'h1);
    step();
    chk("rs_stall_2", 8'(hs3), 8'h1);
    step();
    chk("rs_stall_3", 8'(hs3), 8'h1);
    chk("rs_fwd1_pre", 8'(bus.fwd_sel), 8'hA);
    chk("rs_eev1_pre", 8'(bus.ex_entry_valid), 8'h1);
    bus.nRST = 1'b0;
    #1;
    chk("rs_hs3", 8'(hs3), 8'h0);
    chk("rs_fwd3", 8'(fwd_sel3), 8'h0);
    chk("rs_eev3", 8'(eev3), 8'h0);
    chk("rs_fwd1", 8'(bus.fwd_sel), 8'h0);
    chk("rs_eev1", 8'(bus.ex_entry_valid), 8'h0);
    chk("rs_hs1", 8'(bus.hazard_stall), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
